// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the 16-bit core. Owns the program
//               counter, presents it to an async-read instruction memory and
//               registers the returned word into the IF/ID pipeline register.
//               Supports decode stalls, execute redirects and a halt state.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               imem_addr/imem_data - instruction memory (0-cycle read)
//               stall               - hold PC and IF/ID
//               redirect_valid/pc   - control-transfer target from execute
//               halt_req            - stop fetching
//               ifid_*              - IF/ID pipeline register contents
//               halted              - fetch is in the HALTED state
//               fetch_count         - instructions delivered into IF/ID (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_pc_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       c_cnt_one = 16'd1;

    state_t              r_state,      w_state_nxt;
    logic [ADDR_W-1:0]   r_pc,         w_pc_nxt;
    logic                r_valid,      w_valid_nxt;
    logic [DATA_W-1:0]   r_instr,      w_instr_nxt;
    logic [ADDR_W-1:0]   r_ifid_pc,    w_ifid_pc_nxt;
    logic [ADDR_W-1:0]   r_ifid_pc1,   w_ifid_pc1_nxt;
    logic [15:0]         r_count,      w_count_nxt;
    logic [ADDR_W-1:0]   w_pc_inc;

    // Address width arithmetic: the last word wraps back to word 0.
    assign w_pc_inc = r_pc + c_pc_one;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_ifid_pc  <= '0;
            r_ifid_pc1 <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_instr    <= w_instr_nxt;
            r_ifid_pc  <= w_ifid_pc_nxt;
            r_ifid_pc1 <= w_ifid_pc1_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // Priority: redirect > (halted) > stall > halt_req > normal fetch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_valid_nxt    = r_valid;
        w_instr_nxt    = r_instr;
        w_ifid_pc_nxt  = r_ifid_pc;
        w_ifid_pc1_nxt = r_ifid_pc1;
        w_count_nxt    = r_count;

        if (redirect_valid) begin
            // The word fetched this cycle is on the wrong path: squash to a NOP.
            w_state_nxt = ST_RUN;
            w_pc_nxt    = redirect_pc;
            w_valid_nxt = 1'b0;
            w_instr_nxt = '0;
        end else if (r_state == ST_HALTED) begin
            // Frozen; stall and halt_req have no effect here.
            w_valid_nxt = 1'b0;
        end else if (stall) begin
            // Hold everything (defaults).
        end else if (halt_req) begin
            w_state_nxt = ST_HALTED;
            w_valid_nxt = 1'b0;
            w_instr_nxt = '0;
        end else begin
            w_pc_nxt       = w_pc_inc;
            w_valid_nxt    = 1'b1;
            w_instr_nxt    = imem_data;
            w_ifid_pc_nxt  = r_pc;
            w_ifid_pc1_nxt = w_pc_inc;
            w_count_nxt    = r_count + c_cnt_one;
        end
    end

    assign imem_addr     = r_pc;
    assign ifid_valid    = r_valid;
    assign ifid_instr    = r_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus1 = r_ifid_pc1;
    assign halted        = (r_state == ST_HALTED);
    assign fetch_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: a table of directed
//               per-cycle vectors plus hand-written halt/resume/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [9:0]  ifid_pc;
    logic [9:0]  ifid_pc_plus1;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] imem [1024];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    fetch_stage #(.ADDR_W(10), .DATA_W(16), .RESET_PC(10'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Memory content: every word tagged with its own address.
    function automatic logic [15:0] word_at(input logic [9:0] a);
        return {6'h15, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv,
                         input logic [9:0] rpc, input logic h);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stl, rv;
        logic [9:0]  rpc;
        logic        hlt;
        logic        ev;
        logic [9:0]  epc, epc1, eaddr;
        logic        eh;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic rst, logic stl, logic rv, logic [9:0] rpc, logic hlt,
                                logic ev, logic [9:0] epc, logic [9:0] epc1,
                                logic [9:0] eaddr, logic eh, logic [15:0] ecnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.ev = ev; v.epc = epc; v.epc1 = epc1; v.eaddr = eaddr; v.eh = eh; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = word_at(10'(i));
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);

        //              rst stl rv  rpc     hlt  ev  pc      pc+1    addr    h   cnt
        tbl[0]  = mk(1, 0, 0, 10'd0,    0,   0, 10'd0,    10'd0, 10'd0,    0, 16'd0); // reset
        tbl[1]  = mk(0, 0, 0, 10'd0,    0,   1, 10'd0,    10'd1, 10'd1,    0, 16'd1); // A
        tbl[2]  = mk(0, 0, 0, 10'd0,    0,   1, 10'd1,    10'd2, 10'd2,    0, 16'd2); // B
        tbl[3]  = mk(0, 1, 0, 10'd0,    0,   1, 10'd1,    10'd2, 10'd2,    0, 16'd2); // stall
        tbl[4]  = mk(0, 1, 0, 10'd0,    0,   1, 10'd1,    10'd2, 10'd2,    0, 16'd2); // stall
        tbl[5]  = mk(0, 0, 0, 10'd0,    0,   1, 10'd2,    10'd3, 10'd3,    0, 16'd3); // C
        tbl[6]  = mk(0, 0, 0, 10'd0,    0,   1, 10'd3,    10'd4, 10'd4,    0, 16'd4); // D
        tbl[7]  = mk(0, 1, 1, 10'd7,    0,   0, 10'd3,    10'd4, 10'd7,    0, 16'd4); // redirect+stall
        tbl[8]  = mk(0, 0, 0, 10'd0,    0,   1, 10'd7,    10'd8, 10'd8,    0, 16'd5);
        tbl[9]  = mk(0, 1, 0, 10'd0,    1,   1, 10'd7,    10'd8, 10'd8,    0, 16'd5); // stall beats halt
        tbl[10] = mk(0, 0, 0, 10'd0,    1,   0, 10'd7,    10'd8, 10'd8,    1, 16'd5); // halt
        tbl[11] = mk(0, 1, 0, 10'd0,    1,   0, 10'd7,    10'd8, 10'd8,    1, 16'd5); // halted ignores
        tbl[12] = mk(0, 0, 1, 10'd1023, 0,   0, 10'd7,    10'd8, 10'd1023, 0, 16'd5); // resume
        tbl[13] = mk(0, 0, 0, 10'd0,    0,   1, 10'd1023, 10'd0, 10'd0,    0, 16'd6); // wrap
        tbl[14] = mk(0, 0, 0, 10'd0,    0,   1, 10'd0,    10'd1, 10'd1,    0, 16'd7);
        tbl[15] = mk(1, 0, 0, 10'd0,    0,   0, 10'd0,    10'd0, 10'd0,    0, 16'd0); // reset

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rv, tbl[i].rpc, tbl[i].hlt);
            step();
            chk($sformatf("row%0d valid", i), 32'(ifid_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].eh));
            chk($sformatf("row%0d count", i), 32'(fetch_count), 32'(tbl[i].ecnt));
            if (tbl[i].ev || tbl[i].rst) begin
                chk($sformatf("row%0d pc", i), 32'(ifid_pc), 32'(tbl[i].epc));
                chk($sformatf("row%0d pc1", i), 32'(ifid_pc_plus1), 32'(tbl[i].epc1));
            end
            if (tbl[i].ev || tbl[i].rst || tbl[i].rv)
                chk($sformatf("row%0d instr", i), 32'(ifid_instr),
                    tbl[i].ev ? 32'(word_at(tbl[i].epc)) : 32'd0);
        end

        // Halt, stay frozen 10 cycles regardless of stall/halt_req, then resume at 5.
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        step(); step();                          // fetched words 0,1 -> count 2, pc 2
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        step();
        chk("halt enter", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'(i % 2), 1'b0, 10'd0, 1'(i % 3 != 0));
            step();
            chk("halt hold", 32'(halted), 32'd1);
            chk("halt valid", 32'(ifid_valid), 32'd0);
            chk("halt pc", 32'(imem_addr), 32'd2);
            chk("halt count", 32'(fetch_count), 32'd2);
        end
        drive(1'b0, 1'b0, 1'b1, 10'd5, 1'b0);
        step();
        chk("resume halted", 32'(halted), 32'd0);
        chk("resume bubble", 32'(ifid_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        step();
        chk("resume valid", 32'(ifid_valid), 32'd1);
        chk("resume pc", 32'(ifid_pc), 32'd5);
        chk("resume pc1", 32'(ifid_pc_plus1), 32'd6);
        chk("resume instr", 32'(ifid_instr), 32'(word_at(10'd5)));
        chk("resume count", 32'(fetch_count), 32'd3);

        // Run to count 9, halt, then reset from HALTED.
        for (int i = 0; i < 6; i++) step();
        chk("run count", 32'(fetch_count), 32'd9);
        chk("run pc", 32'(ifid_pc), 32'd11);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        step();
        chk("halt2", 32'(halted), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        step();
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst valid", 32'(ifid_valid), 32'd0);
        chk("rst instr", 32'(ifid_instr), 32'd0);
        chk("rst pc", 32'(ifid_pc), 32'd0);
        chk("rst pc1", 32'(ifid_pc_plus1), 32'd0);
        chk("rst addr", 32'(imem_addr), 32'd0);
        chk("rst count", 32'(fetch_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
